hwpe_stream_source_realigner: RTL and testbench

HWPE_STREAM_SOURCE_REALIGNER -- requirements
Module: hwpe_stream_source_realigner

---
 rtl/hwpe_stream_package.sv | 37 +++
 rtl/hwpe_stream_intf_stream.sv | 16 +
 rtl/hwpe_stream_realign_merge.sv | 30 +++
 rtl/hwpe_stream_source_realigner.sv | 197 +++++++++++++++++++
 tb/tb_hwpe_stream_source_realigner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types for the stream realigner.
//   realign_state_e : control states of hwpe_stream_source_realigner
//   realign_cfg_t   : per-job configuration latched on start
//   realign_ceil_div: word count of a byte span, rounded up
// Config fields are sized for the widest supported stream (DATA_WIDTH 512,
// 64-byte words) and for length fields up to 32 bits.
package hwpe_stream_package;

  localparam int unsigned REALIGN_OFF_W = 6;
  localparam int unsigned REALIGN_LEN_W = 32;

  typedef enum logic [2:0] {
    REALIGN_IDLE,
    REALIGN_FIRST,
    REALIGN_STREAM,
    REALIGN_DRAIN,
    REALIGN_DONE
  } realign_state_e;

  typedef struct packed {
    logic [REALIGN_OFF_W-1:0] offset;
    logic [REALIGN_LEN_W-1:0] byte_len;
    logic [REALIGN_LEN_W-1:0] n_lines;
  } realign_cfg_t;

  // ceil(bytes / 2**off_width); the sum is two bits wider than a length
  // field so that offset + byte_len + NB - 1 never wraps.
  function automatic logic [REALIGN_LEN_W-1:0] realign_ceil_div(
    input logic [REALIGN_LEN_W:0] bytes,
    input int unsigned            off_width
  );
    logic [REALIGN_LEN_W+1:0] sum;
    sum = {1'b0, bytes} + ((REALIGN_LEN_W+2)'(1) << off_width) - (REALIGN_LEN_W+2)'(1);
    return REALIGN_LEN_W'(sum >> off_width);
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle.
//   valid, data, strb : driven by the source
//   ready             : driven by the sink
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_realign_merge.sv
// Combinational shift/merge of two consecutive aligned words.
//   hold_i   : older word (its bytes above offset_i come first)
//   data_i   : newer word (its low bytes fill the top of the result)
//   offset_i : byte offset of the first wanted byte in hold_i
//   drain_i  : no newer word exists; upper result bytes are zero
//   merged_o : realigned word
module hwpe_stream_realign_merge
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]    hold_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic [REALIGN_OFF_W-1:0] offset_i,
  input  logic                     drain_i,
  output logic [DATA_WIDTH-1:0]    merged_o
);

  logic [REALIGN_OFF_W+3:0] shift_lo;
  logic [REALIGN_OFF_W+3:0] shift_hi;

  assign shift_lo = {1'b0, offset_i, 3'b000};
  // With offset 0 this equals DATA_WIDTH, so the newer word shifts out
  // entirely instead of being OR-ed in.
  assign shift_hi = (REALIGN_OFF_W+4)'(DATA_WIDTH) - shift_lo;

  assign merged_o = drain_i ? (hold_i >> shift_lo)
                            : ((hold_i >> shift_lo) | (data_i << shift_hi));

endmodule

// File: rtl/hwpe_stream_source_realigner.sv
// Realigns lines of bytes that start at an arbitrary byte offset inside
// NB-aligned input words into output words that start at byte 0.
//   clk_i, rst_i, clear_i : clock, synchronous active-high reset / soft clear
//   start_i               : launch a job (accepted only when idle)
//   offset_i, byte_len_i, n_lines_i : job configuration, latched on start
//   stream_i              : aligned input words
//   stream_o              : realigned output words, strb marks valid bytes
//   busy_o, done_o        : job in progress / one-cycle completion pulse
// LEN_WIDTH is expected to be at most 32.
module hwpe_stream_source_realigner
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned NB         = DATA_WIDTH / 8,
  parameter int unsigned OFF_WIDTH  = $clog2(NB)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [OFF_WIDTH-1:0]   offset_i,
  input  logic [LEN_WIDTH-1:0]   byte_len_i,
  input  logic [LEN_WIDTH-1:0]   n_lines_i,
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o,
  output logic                   busy_o,
  output logic                   done_o
);

  realign_state_e           state_q, state_d;
  realign_cfg_t             cfg_q, cfg_d;
  logic [REALIGN_LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [REALIGN_LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [REALIGN_LEN_W-1:0] line_cnt_q, line_cnt_d;
  logic [DATA_WIDTH-1:0]    hold_q, hold_d;

  logic [REALIGN_LEN_W-1:0] in_words, out_words;
  logic                     offset_zero, last_out, last_line, end_line;
  logic                     in_ready, out_valid, in_hs, out_hs;
  logic [DATA_WIDTH-1:0]    merged, out_data;
  logic [NB-1:0]            out_strb, last_strb;
  logic [OFF_WIDTH-1:0]     last_idx;

  assign out_words   = realign_ceil_div({1'b0, cfg_q.byte_len}, OFF_WIDTH);
  assign in_words    = realign_ceil_div({1'b0, cfg_q.byte_len} + (REALIGN_LEN_W+1)'(cfg_q.offset),
                                        OFF_WIDTH);
  assign offset_zero = (cfg_q.offset == '0);
  assign last_out    = (out_cnt_q == out_words - 1);
  assign last_line   = (line_cnt_q == cfg_q.n_lines - 1);
  assign in_hs       = stream_i.valid & in_ready;
  assign out_hs      = out_valid & stream_o.ready;

  hwpe_stream_realign_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) i_merge (
    .hold_i   (hold_q),
    .data_i   (stream_i.data),
    .offset_i (cfg_q.offset),
    .drain_i  (state_q == REALIGN_DRAIN),
    .merged_o (merged)
  );

  // Index of the last valid byte in the final word of a line; wraps to
  // NB-1 when byte_len is a multiple of NB.
  assign last_idx = cfg_q.byte_len[OFF_WIDTH-1:0] - OFF_WIDTH'(1);

  always_comb begin
    for (int unsigned b = 0; b < NB; b++) begin
      last_strb[b] = (b <= 32'(last_idx));
    end
  end

  // With offset 0 the stream is a zero-latency passthrough; otherwise the
  // output is stitched from the hold register and the incoming word.
  assign out_data = (state_q == REALIGN_STREAM && offset_zero) ? stream_i.data : merged;
  assign out_strb = last_out ? last_strb : '1;

  assign stream_i.ready = in_ready;
  assign stream_o.valid = out_valid;
  assign stream_o.data  = out_data;
  assign stream_o.strb  = out_strb;

  assign busy_o = (state_q != REALIGN_IDLE);
  assign done_o = (state_q == REALIGN_DONE);

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cfg_d      = cfg_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    line_cnt_d = line_cnt_q;
    hold_d     = hold_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    end_line   = 1'b0;

    case (state_q)
      REALIGN_IDLE: begin
        if (start_i) begin
          cfg_d.offset   = REALIGN_OFF_W'(offset_i);
          cfg_d.byte_len = REALIGN_LEN_W'(byte_len_i);
          cfg_d.n_lines  = REALIGN_LEN_W'(n_lines_i);
          in_cnt_d       = '0;
          out_cnt_d      = '0;
          line_cnt_d     = '0;
          if (byte_len_i == '0 || n_lines_i == '0) begin
            state_d = REALIGN_DONE;
          end else if (offset_i != '0) begin
            state_d = REALIGN_FIRST;
          end else begin
            state_d = REALIGN_STREAM;
          end
        end
      end

      REALIGN_FIRST: begin
        in_ready = 1'b1;
        if (in_hs) begin
          hold_d   = stream_i.data;
          in_cnt_d = in_cnt_q + 1;
          // A line that fits in a single input word has nothing to merge.
          state_d  = (in_cnt_q + 1 == in_words) ? REALIGN_DRAIN : REALIGN_STREAM;
        end
      end

      REALIGN_STREAM: begin
        out_valid = stream_i.valid;
        in_ready  = stream_o.ready;
        if (out_hs) begin
          in_cnt_d  = in_cnt_q + 1;
          out_cnt_d = out_cnt_q + 1;
          if (!offset_zero) begin
            hold_d = stream_i.data;
          end
          if (last_out) begin
            end_line = 1'b1;
          end else if (in_cnt_q + 1 == in_words) begin
            state_d = REALIGN_DRAIN;
          end
        end
      end

      REALIGN_DRAIN: begin
        out_valid = 1'b1;
        if (out_hs) begin
          end_line = 1'b1;
        end
      end

      REALIGN_DONE: begin
        state_d = REALIGN_IDLE;
      end

      default: begin
        state_d = REALIGN_IDLE;
      end
    endcase

    if (end_line) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      if (last_line) begin
        line_cnt_d = '0;
        state_d    = REALIGN_DONE;
      end else begin
        line_cnt_d = line_cnt_q + 1;
        state_d    = offset_zero ? REALIGN_STREAM : REALIGN_FIRST;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= REALIGN_IDLE;
      cfg_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      line_cnt_q <= '0;
      // NOTE: the hold register is a plain data word, but it is cleared too
      // so an aborted job leaves no stale bytes behind.
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      line_cnt_q <= line_cnt_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_source_realigner.sv
module tb_hwpe_stream_source_realigner;

  localparam int unsigned DW     = 32;
  localparam int          BUDGET = 1000;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, start_i;
  logic [1:0]  offset_i;
  logic [15:0] byte_len_i, n_lines_i;
  logic        busy_o, done_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s_in ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s_out ();

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] words [0:255];

  always #5 clk = ~clk;

  hwpe_stream_source_realigner #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .offset_i   (offset_i),
    .byte_len_i (byte_len_i),
    .n_lines_i  (n_lines_i),
    .stream_i   (s_in),
    .stream_o   (s_out),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Input memory: directed mode gives byte k the value k.
  task automatic fill_words(input bit directed);
    for (int i = 0; i < 256; i++) begin
      if (directed) words[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      else          words[i] = $urandom;
    end
  endtask

  // rdy_mode: 0 always ready, 1 toggling, 2 random.  vld_mode: 0 always
  // valid when data remains, 1 random gaps.  abort_kind: 0 none, 1 rst_i,
  // 2 clear_i after the first output.  poke: extra start_i while busy.
  task automatic run_job(input int off, input int blen, input int nl,
                         input int rdy_mode, input int vld_mode,
                         input int abort_kind, input bit poke);
    logic [31:0] exp_d [$];
    logic [3:0]  exp_s [$];
    int total_in, w, iw, ow, in_idx, cyc, done_cnt, done_cyc, last_out_cyc, n_out, post;
    bit held, done_seen, prev_stall;
    logic [31:0] prev_d;
    logic [3:0]  prev_s;

    // Reference: a line is the byte string of its consumed input words;
    // output byte b of word j is line byte off+4j+b, zero past the end.
    w = 0;
    if (blen > 0 && nl > 0) begin
      for (int l = 0; l < nl; l++) begin
        iw = (off + blen + 3) / 4;
        ow = (blen + 3) / 4;
        for (int j = 0; j < ow; j++) begin
          logic [31:0] d;
          d = '0;
          for (int b = 0; b < 4; b++) begin
            int k;
            k = off + 4*j + b;
            if (k < 4*iw) d[8*b +: 8] = words[w + k/4][8*(k%4) +: 8];
          end
          exp_d.push_back(d);
          exp_s.push_back((j == ow-1) ? 4'((1 << (((blen-1) % 4) + 1)) - 1) : 4'hF);
        end
        w += iw;
      end
    end
    total_in = w;

    @(posedge clk); #1;
    start_i     = 1'b1;
    offset_i    = 2'(off);
    byte_len_i  = 16'(blen);
    n_lines_i   = 16'(nl);
    s_in.valid  = 1'b0;
    s_out.ready = 1'b1;

    in_idx = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_out_cyc = -10;
    n_out = 0; post = 0; held = 0; done_seen = 0; prev_stall = 0;
    prev_d = '0; prev_s = '0;

    while (1) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_start", busy_o, 1'b1);
      if (prev_stall) begin
        check("stall_valid", s_out.valid, 1'b1);
        check("stall_data", s_out.data, prev_d);
        check("stall_strb", s_out.strb, prev_s);
      end
      if (s_out.valid && s_out.ready) begin
        n_out++;
        last_out_cyc = cyc;
        if (n_out > exp_d.size()) begin
          check("out_count", n_out, exp_d.size());
        end else begin
          check("out_data", s_out.data, exp_d[n_out-1]);
          check("out_strb", s_out.strb, exp_s[n_out-1]);
        end
      end
      prev_stall = s_out.valid && !s_out.ready;
      prev_d     = s_out.data;
      prev_s     = s_out.strb;
      if (s_in.valid && s_in.ready) begin
        in_idx++;
        held = 0;
      end else begin
        held = s_in.valid;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1;
      end

      if (abort_kind != 0 && n_out == 1) begin
        @(posedge clk); #1;
        if (abort_kind == 1) rst_i = 1'b1;
        else                 clear_i = 1'b1;
        s_in.valid = 1'b0;
        start_i    = 1'b0;
        @(posedge clk); #1;
        rst_i   = 1'b0;
        clear_i = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", s_out.valid, 1'b0);
        check("abort_ready", s_in.ready, 1'b0);
        check("abort_done", done_o, 1'b0);
        return;
      end

      if (done_seen) post++;
      if (post == 3) break;
      if (cyc >= BUDGET) begin
        check("timeout", done_seen, 1'b1);
        break;
      end

      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      if (poke && cyc == 1) begin
        start_i    = 1'b1;
        offset_i   = 2'($urandom);
        byte_len_i = 16'($urandom);
        n_lines_i  = 16'($urandom);
      end
      if (!held) begin
        if (in_idx < total_in && (vld_mode == 0 || $urandom_range(0, 2) != 0)) begin
          s_in.valid = 1'b1;
          s_in.data  = words[in_idx];
        end else begin
          s_in.valid = 1'b0;
        end
      end
      case (rdy_mode)
        0:       s_out.ready = 1'b1;
        1:       s_out.ready = (cyc % 2 == 0);
        default: s_out.ready = 1'($urandom_range(0, 1));
      endcase
    end

    check("out_count", n_out, exp_d.size());
    check("in_count", in_idx, total_in);
    check("done_pulses", done_cnt, 1);
    if (n_out > 0) check("done_latency", done_cyc, last_out_cyc + 1);
    check("idle_after", busy_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    offset_i = '0; byte_len_i = '0; n_lines_i = '0;
    s_in.valid = 1'b0; s_in.data = '0; s_in.strb = '1; s_out.ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_valid", s_out.valid, 1'b0);
    check("reset_ready", s_in.ready, 1'b0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    fill_words(1'b1);
    run_job(0, 8, 1, 0, 0, 0, 0);   // passthrough
    run_job(1, 8, 1, 0, 0, 0, 0);   // 3 inputs, 2 outputs
    run_job(2, 6, 1, 0, 0, 0, 0);   // ends in drain
    run_job(1, 8, 1, 1, 0, 0, 0);   // toggling ready
    run_job(3, 5, 2, 0, 0, 0, 0);   // two lines
    run_job(3, 1, 1, 0, 0, 0, 0);   // single input word, straight to drain
    run_job(0, 5, 3, 2, 1, 0, 0);   // passthrough with partial last word
    run_job(1, 0, 1, 0, 0, 0, 0);   // zero length
    run_job(2, 4, 0, 0, 0, 0, 0);   // zero lines
    run_job(2, 10, 2, 2, 1, 0, 1);  // start while busy

    run_job(1, 8, 1, 0, 0, 1, 0);   // reset mid-line
    run_job(1, 8, 1, 0, 0, 0, 0);
    run_job(2, 13, 2, 0, 0, 2, 0);  // clear mid-line
    run_job(2, 13, 2, 2, 1, 0, 0);

    @(posedge clk); #1;
    clear_i = 1'b1; start_i = 1'b1;
    offset_i = 2'd1; byte_len_i = 16'd8; n_lines_i = 16'd1;
    @(posedge clk); #1;
    clear_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("clear_beats_start_busy", busy_o, 1'b0);
    check("clear_beats_start_ready", s_in.ready, 1'b0);

    for (int t = 0; t < 40; t++) begin
      fill_words(1'b0);
      run_job($urandom_range(0, 3), $urandom_range(1, 40), $urandom_range(1, 3),
              $urandom_range(0, 2), $urandom_range(0, 1), 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
